// File: rtl/memory_stage.sv
// MEM pipeline stage: word-organised data RAM with byte/half/word little-endian
// loads and stores, misalignment trapping and a wait-state FSM that stalls upstream.
module memory_stage #(
    parameter int ADDR_SIZE   = 10,
    parameter int WORD_SIZE   = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WORD_SIZE-1:0] alu_data_ex_mem,
    input  logic [WORD_SIZE-1:0] rt_data_ex_mem,
    input  logic                 mem_rd_ex_mem,
    input  logic                 mem_wr_ex_mem,
    input  logic [1:0]           mem_size_ex_mem,
    input  logic                 mem_signed_ex_mem,
    input  logic                 rd_en_ex_mem,
    input  logic [4:0]           rd_addr_ex_mem,
    input  logic                 rd_data_sel_ex_mem,
    output logic                 stall,
    output logic [WORD_SIZE-1:0] alu_data_mem_wb,
    output logic [WORD_SIZE-1:0] mem_data_mem_wb,
    output logic                 rd_en_mem_wb,
    output logic [4:0]           rd_addr_mem_wb,
    output logic                 rd_data_sel_mem_wb,
    output logic                 misalign_mem_wb
);
    localparam int NB = WORD_SIZE / 8;
    localparam int L  = $clog2(NB);
    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t state, state_nxt;
    logic [3:0] cnt, cnt_nxt;

    logic [WORD_SIZE-1:0] ram [0:(2**ADDR_SIZE)-1];

    logic [ADDR_SIZE-1:0] widx_p0;
    logic [L-1:0]         off_p0;
    logic                 is_mem_p0, misalign_p0, access_p0, vld_p0;
    logic [NB-1:0]        be_p0;
    logic [WORD_SIZE-1:0] wdata_p0, rdata_p0, load_p0;

    // Lane select and sign/zero extension of a loaded word.
    function automatic logic [WORD_SIZE-1:0] load_lane(input logic [WORD_SIZE-1:0] w,
                                                       input logic [L-1:0] o,
                                                       input logic [1:0] sz,
                                                       input logic sgn);
        logic [WORD_SIZE-1:0] sh;
        logic signed [7:0]    b;
        logic signed [15:0]   h;
        logic [WORD_SIZE-1:0] r;
        sh = w >> {o, 3'b000};
        b  = sh[7:0];
        h  = sh[15:0];
        if (sz[1])
            r = w;
        else if (sz[0])
            r = sgn ? WORD_SIZE'(h) : WORD_SIZE'(sh[15:0]);
        else
            r = sgn ? WORD_SIZE'(b) : WORD_SIZE'(sh[7:0]);
        return r;
    endfunction

    function automatic logic [NB-1:0] store_be(input logic [L-1:0] o, input logic [1:0] sz);
        logic [NB-1:0] r;
        if (sz[1])
            r = '1;
        else if (sz[0])
            r = NB'(3) << o;
        else
            r = NB'(1) << o;
        return r;
    endfunction

    function automatic logic [WORD_SIZE-1:0] store_data(input logic [WORD_SIZE-1:0] rt,
                                                        input logic [1:0] sz);
        logic [WORD_SIZE-1:0] r;
        if (sz[1])
            r = rt;
        else if (sz[0])
            r = {(NB/2){rt[15:0]}};
        else
            r = {NB{rt[7:0]}};
        return r;
    endfunction

    assign widx_p0     = alu_data_ex_mem[ADDR_SIZE+L-1:L];
    assign off_p0      = alu_data_ex_mem[L-1:0];
    assign is_mem_p0   = mem_rd_ex_mem | mem_wr_ex_mem;
    assign misalign_p0 = is_mem_p0 &
                         (((mem_size_ex_mem == 2'b01) & off_p0[0]) |
                          (mem_size_ex_mem[1] & (off_p0 != '0)));
    assign access_p0   = is_mem_p0 & ~misalign_p0;
    assign be_p0       = store_be(off_p0, mem_size_ex_mem);
    assign wdata_p0    = store_data(rt_data_ex_mem, mem_size_ex_mem);
    assign rdata_p0    = ram[widx_p0];
    assign load_p0     = load_lane(rdata_p0, off_p0, mem_size_ex_mem, mem_signed_ex_mem);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                if (access_p0 && (WAIT_STATES > 0)) begin
                    stall     = 1'b1;
                    state_nxt = WAIT;
                    cnt_nxt   = CNT_INIT;
                end
            end
            WAIT: begin
                if (cnt != 4'd0) begin
                    stall   = 1'b1;
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The instruction in EX/MEM retires on this edge whenever we are not stalling.
    assign vld_p0 = ~stall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Gated by rst_n so a reset landing on the completing edge aborts the store.
    always_ff @(posedge clk) begin
        if (rst_n && vld_p0 && access_p0 && mem_wr_ex_mem) begin
            for (int i = 0; i < NB; i++) begin
                if (be_p0[i])
                    ram[widx_p0][8*i +: 8] <= wdata_p0[8*i +: 8];
            end
        end
    end

    // ---- MEM/WB boundary ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_data_mem_wb    <= '0;
            mem_data_mem_wb    <= '0;
            rd_en_mem_wb       <= 1'b0;
            rd_addr_mem_wb     <= 5'd0;
            rd_data_sel_mem_wb <= 1'b0;
            misalign_mem_wb    <= 1'b0;
        end else if (vld_p0) begin
            alu_data_mem_wb    <= alu_data_ex_mem;
            mem_data_mem_wb    <= (access_p0 && !mem_wr_ex_mem) ? load_p0 : '0;
            rd_en_mem_wb       <= rd_en_ex_mem & ~misalign_p0;
            rd_addr_mem_wb     <= rd_addr_ex_mem;
            rd_data_sel_mem_wb <= rd_data_sel_ex_mem;
            misalign_mem_wb    <= misalign_p0;
        end else begin
            rd_en_mem_wb       <= 1'b0;
            misalign_mem_wb    <= 1'b0;
        end
    end
endmodule

// File: doc/memory_stage.md
# memory_stage

Parametrised MEM pipeline stage for the MIPS core, sitting between EX/MEM and MEM/WB. It holds a word-organised data RAM and supports byte, halfword and word loads and stores, little-endian, with sign or zero extension. Misaligned accesses are trapped and flagged. A configurable wait-state FSM stalls upstream stages for slow memory. Non-memory instructions pass straight through to writeback with one cycle of latency.

## Interface
- ADDR_SIZE, 10, word-address bits; RAM depth is 2**ADDR_SIZE words.
- WORD_SIZE, 32, data width in bits; power of two, at least 32; L = log2(WORD_SIZE/8) byte-offset bits.
- WAIT_STATES, 0, extra cycles per memory access, 0..15.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- alu_data_ex_mem  in  WORD_SIZE  ALU result; this is the byte address for memory operations.
- rt_data_ex_mem  in  WORD_SIZE  store data.
- mem_rd_ex_mem  in  1  load.
- mem_wr_ex_mem  in  1  store; takes priority if asserted together with mem_rd_ex_mem.
- mem_size_ex_mem  in  2  access size: 00 byte, 01 half, 10 and 11 full word.
- mem_signed_ex_mem  in  1  load sign-extends when 1, zero-extends when 0.
- rd_en_ex_mem  in  1  register-write enable.
- rd_addr_ex_mem  in  5  destination register.
- rd_data_sel_ex_mem  in  1  writeback source select (passed through).
- stall  out  1  combinational; while high, upstream holds all *_ex_mem inputs stable.
- alu_data_mem_wb, mem_data_mem_wb  out  WORD_SIZE  registered ALU result and load result.
- rd_en_mem_wb  out  1  registered register-write enable.
- rd_addr_mem_wb  out  5  registered destination register.
- rd_data_sel_mem_wb  out  1  registered writeback source select.
- misalign_mem_wb  out  1  registered alignment-fault flag.

## Operation
- Address fields:
  - word index = alu_data_ex_mem[ADDR_SIZE+L-1:L];
  - byte offset = alu_data_ex_mem[L-1:0];
  - upper address bits are ignored.
- Misaligned access:
  - A half access is misaligned when offset bit 0 is 1; a word access is misaligned when the offset is nonzero.
  - Response: no RAM write, mem_data_mem_wb = 0, misalign_mem_wb = 1, rd_en_mem_wb = 0.
  - Never stalls.
- Stores:
  - The low byte or half of rt is replicated across lanes.
  - Byte enables select only the addressed lane(s); all other bytes of the word are preserved.
- Loads:
  - Select the lane at the offset; byte in lane 0 = bits [7:0] (little-endian).
  - Extend to WORD_SIZE per mem_signed_ex_mem.
- "Access" = (mem_rd_ex_mem | mem_wr_ex_mem) and aligned.
- FSM, states IDLE and WAIT, with a 4-bit counter cnt:
  - IDLE, access, WAIT_STATES>0: stall=1, go to WAIT, cnt <= WAIT_STATES-1; MEM/WB loads a bubble.
  - IDLE, otherwise: stall=0; the instruction completes this edge.
  - WAIT, cnt != 0: stall=1, cnt decrements, bubble.
  - WAIT, cnt == 0: stall=0, the access completes this edge, go to IDLE.
- Bubble: rd_en_mem_wb = 0 and misalign_mem_wb = 0; the other outputs are don't-care.
- RAM write and read sampling happen only on the completing edge.
- Reset:
  - state IDLE, cnt 0, all *_mem_wb outputs 0; stall is 0 in the cycle after reset.
  - RAM contents are not reset; simulation initialises them to 0.
  - Reset asserted during WAIT aborts the access: no write occurs.

## Timing
- Non-memory ops and misaligned ops: 1-cycle latency, no stall.
- Memory ops: stall high for exactly WAIT_STATES cycles; the result appears WAIT_STATES+1 cycles after presentation.
- Back-to-back accesses each pay the full wait count; WAIT is never skipped.
- A load directly following a store to the same word returns the new data, because the store completed on an earlier edge.

## Test plan
- Config W=0, WORD_SIZE=32:
  - Store word 0xDEADBEEF at 0x10, then load word at 0x10 → mem_data_mem_wb = 0xDEADBEEF one cycle later; stall stays 0.
  - Store byte 0x80 at 0x13, then:
    - load byte signed at 0x13 → 0xFFFFFF80;
    - load byte unsigned at 0x13 → 0x00000080;
    - load word at 0x10 → 0x80ADBEEF.
  - Load half at 0x11 with rd_en=1 → misalign_mem_wb=1, rd_en_mem_wb=0, mem_data=0. A following store half at 0x11 leaves word 0x10 unchanged.
- Config W=2:
  - Load word held for three cycles → stall = 1,1,0; rd_en_mem_wb = 0,0,1 on the following edges; data correct.
  - ALU op with rd_en=1, rd_addr=7, alu=0x1234 → no stall; next cycle alu_data_mem_wb = 0x1234, rd_addr_mem_wb = 7.
- Reset during WAIT: pull rst_n low while a store of 0x55 to 0x20 is in WAIT → next cycle stall=0 and all outputs 0; a later load of 0x20 returns the old value.
